// File: rtl/bound_flasher_param.sv
// bound_flasher_param: parametrised LED bound flasher.
// Drives an LED_NUM-bit thermometer bar through a three-phase up/down ramp
// started by flick, with kickback points at BOUND_LO and BOUND_MID.
// Steps advance once every DIV clocks on a free-running prescaler tick.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flick     : start / kickback request, sampled on tick cycles only
//   led_state : registered thermometer output, bits [c-1:0] set
//   busy      : registered, high while a sequence is in progress
//   done      : registered one-clock pulse when the sequence returns to idle
//
// Build option: define BOUND_FLASHER_KICKBACK_EN to enable the flick-driven
// kickback transitions in S2_UP and S3_UP. Without it flick only starts a
// sequence from IDLE.
module bound_flasher_param #(
    parameter int unsigned LED_NUM   = 16,
    parameter int unsigned BOUND_LO  = 5,
    parameter int unsigned BOUND_MID = 10,
    parameter int unsigned DIV       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flick,
    output logic [LED_NUM-1:0] led_state,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(LED_NUM + 1);
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] C_MAX = CW'(LED_NUM);
    localparam logic [CW-1:0] C_LO  = CW'(BOUND_LO);
    localparam logic [CW-1:0] C_MID = CW'(BOUND_MID);
    localparam logic [PW-1:0] P_END = PW'(DIV - 1);

`ifdef BOUND_FLASHER_KICKBACK_EN
    localparam bit KICK_EN = 1'b1;
`else
    localparam bit KICK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1_UP = 3'd1,
        S1_DN = 3'd2,
        S2_UP = 3'd3,
        S2_DN = 3'd4,
        S3_UP = 3'd5,
        S3_DN = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [PW-1:0]      pre, pre_nxt;
    logic [LED_NUM-1:0] led_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               tick_c;
    logic [CW-1:0]      cnt_inc_c;
    logic [CW-1:0]      cnt_dec_c;

    assign tick_c    = (pre == P_END);
    assign cnt_inc_c = cnt + CW'(1);
    assign cnt_dec_c = cnt - CW'(1);

    // State, count, prescaler and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pre       <= '0;
            led_state <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pre       <= pre_nxt;
            led_state <= led_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state, next-count and output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        pre_nxt   = tick_c ? '0 : pre + PW'(1);

        if (tick_c) begin
            unique case (state)
                IDLE: begin
                    if (flick) begin
                        state_nxt = S1_UP;
                        cnt_nxt   = CW'(1);
                    end
                end
                S1_UP: begin
                    cnt_nxt = cnt_inc_c;
                    if (cnt_inc_c == C_MAX) state_nxt = S1_DN;
                end
                S1_DN: begin
                    cnt_nxt = cnt_dec_c;
                    if (cnt_dec_c == C_LO) state_nxt = S2_UP;
                end
                S2_UP: begin
                    cnt_nxt = cnt_inc_c;
                    if (cnt_inc_c == C_MID) begin
                        // Kickback repeats the LO->MID leg via S1_DN
                        state_nxt = (KICK_EN && flick) ? S1_DN : S2_DN;
                    end
                end
                S2_DN: begin
                    cnt_nxt = cnt_dec_c;
                    if (cnt_dec_c == '0) state_nxt = S3_UP;
                end
                S3_UP: begin
                    cnt_nxt = cnt_inc_c;
                    if (cnt_inc_c == C_MAX) begin
                        state_nxt = S3_DN;
                    end else if (KICK_EN && flick &&
                                 (cnt_inc_c == C_LO || cnt_inc_c == C_MID)) begin
                        // Kickback ramps back to 0 and repeats the 0->N phase
                        state_nxt = S2_DN;
                    end
                end
                S3_DN: begin
                    cnt_nxt = cnt_dec_c;
                    if (cnt_dec_c == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);

        // Thermometer decode of the next count so led_state tracks c exactly
        led_nxt = '0;
        for (int unsigned i = 0; i < LED_NUM; i++) begin
            led_nxt[i] = (CW'(i) < cnt_nxt);
        end
    end

endmodule
